ram512: RTL and testbench



---
 rtl/ram512_pkg.sv | 15 +
 rtl/ram64.sv | 36 +++
 rtl/ram512.sv | 43 ++++
 tb/tb_ram512.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram512_pkg.sv
// Shared sizing constants and types for the RAM8/RAM64/RAM512 hierarchy.
package ram512_pkg;

   localparam int RAM512_ADDR_W = 9;
   localparam int RAM64_ADDR_W  = 6;
   localparam int WORD_W        = 16;
   localparam int BANK_SEL_W    = 3;
   localparam int NUM_BANKS     = 1 << BANK_SEL_W;
   localparam int RAM64_DEPTH   = 1 << RAM64_ADDR_W;

   typedef logic [WORD_W-1:0]       word_t;
   typedef logic [BANK_SEL_W-1:0]   bank_sel_t;
   typedef logic [RAM64_ADDR_W-1:0] bank_addr_t;

endpackage

// File: rtl/ram64.sv
// 64x16 bank: synchronous write and clear, combinational read.
module ram64
   import ram512_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  bank_addr_t address,
   input  word_t      in,
   input  logic       load,
   output word_t      out
);

   word_t mem_q [RAM64_DEPTH];
   word_t mem_d [RAM64_DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (load) begin
         mem_d[address] = in;
      end
   end

   // Clear wins over a same-edge load, so the pending write is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RAM64_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign out = mem_q[address];

endmodule

// File: rtl/ram512.sv
// 512x16 RAM built from eight ram64 banks selected by the top address bits.
module ram512
   import ram512_pkg::*;
#(
   parameter int ADDRESS_WIDTH = RAM512_ADDR_W,
   parameter int DATA_WIDTH    = WORD_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDRESS_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0]    in,
   input  logic                     load,
   output logic [DATA_WIDTH-1:0]    out
);

   bank_sel_t              bank_sel;
   bank_addr_t             bank_addr;
   logic [NUM_BANKS-1:0]   bank_load;
   word_t                  bank_out [NUM_BANKS];

   assign bank_sel  = address[ADDRESS_WIDTH-1 -: BANK_SEL_W];
   assign bank_addr = address[RAM64_ADDR_W-1:0];

   // Only the addressed bank sees load; the others hold unconditionally.
   always_comb begin
      bank_load = '0;
      bank_load[bank_sel] = load;
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      ram64 u_bank (
         .clk     (clk),
         .reset   (reset),
         .address (bank_addr),
         .in      (in),
         .load    (bank_load[b]),
         .out     (bank_out[b])
      );
   end

   assign out = bank_out[bank_sel];

endmodule

// File: tb/tb_ram512.sv
// Randomized self-checking bench for ram512 against an array reference model.
module tb_ram512;

   logic        clk;
   logic        reset;
   logic [8:0]  address;
   logic [15:0] in;
   logic        load;
   logic [15:0] out;

   logic [15:0] ref_mem [512];
   int          n_cmp;
   int          n_err;

   ram512 dut (
      .clk     (clk),
      .reset   (reset),
      .address (address),
      .in      (in),
      .load    (load),
      .out     (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and update the model with what that edge does.
   task automatic clock_edge();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 512; i++) ref_mem[i] = 16'h0000;
      end else if (load) begin
         ref_mem[address] = in;
      end
      #1;
   endtask

   task automatic write_word(input logic [8:0] a, input logic [15:0] d);
      address = a;
      in      = d;
      load    = 1'b1;
      clock_edge();
      load    = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      load  = 1'b0;
      clock_edge();
      reset = 1'b0;
      for (int i = 0; i < 512; i++) begin
         address = 9'(i);
         #1;
         n_cmp++;
         if (out !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_clear addr=%0d got=%h exp=0000", i, out);
         end
      end
   endtask

   task automatic test_full_write();
      for (int i = 0; i < 512; i++) write_word(9'(i), 16'h5A5A + 16'(i));
      for (int i = 0; i < 512; i++) begin
         address = 9'(i);
         #1;
         n_cmp++;
         if (out !== 16'h5A5A + 16'(i)) begin
            n_err++;
            $display("FAIL full_readback addr=%0d got=%h exp=%h", i, out, 16'h5A5A + 16'(i));
         end
      end
      address = 9'd511;
      #1;
      n_cmp++;
      if (out !== 16'h5C59) begin
         n_err++;
         $display("FAIL full_top_word got=%h exp=5C59", out);
      end
   endtask

   task automatic test_hold();
      write_word(9'd100, 16'h1234);
      in   = 16'hFFFF;
      load = 1'b0;
      for (int k = 0; k < 5; k++) begin
         address = 9'($urandom_range(0, 511));
         clock_edge();
      end
      address = 9'd100;
      #1;
      n_cmp++;
      if (out !== 16'h1234) begin
         n_err++;
         $display("FAIL hold_no_load got=%h exp=1234", out);
      end
   endtask

   task automatic test_bank_isolation();
      write_word(9'h03F, 16'hAAAA);
      write_word(9'h040, 16'h5555);
      address = 9'h03F;
      #1;
      n_cmp++;
      if (out !== 16'hAAAA) begin
         n_err++;
         $display("FAIL bank_edge_lo got=%h exp=AAAA", out);
      end
      address = 9'h040;
      #1;
      n_cmp++;
      if (out !== 16'h5555) begin
         n_err++;
         $display("FAIL bank_edge_hi got=%h exp=5555", out);
      end
      address = 9'h1FF;
      #1;
      n_cmp++;
      if (out !== 16'h5C59) begin
         n_err++;
         $display("FAIL bank_untouched got=%h exp=5C59", out);
      end
   endtask

   task automatic test_comb_timing();
      write_word(9'd7, 16'hBEEF);
      address = 9'd8;
      #1;
      n_cmp++;
      if (out !== ref_mem[8]) begin
         n_err++;
         $display("FAIL comb_addr8 got=%h exp=%h", out, ref_mem[8]);
      end
      address = 9'd7;
      #1;
      n_cmp++;
      if (out !== 16'hBEEF) begin
         n_err++;
         $display("FAIL comb_addr7 got=%h exp=BEEF", out);
      end
      in   = 16'hCAFE;
      load = 1'b1;
      #1;
      n_cmp++;
      if (out !== 16'hBEEF) begin
         n_err++;
         $display("FAIL write_before_edge got=%h exp=BEEF", out);
      end
      clock_edge();
      load = 1'b0;
      n_cmp++;
      if (out !== 16'hCAFE) begin
         n_err++;
         $display("FAIL write_after_edge got=%h exp=CAFE", out);
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0]  a;
      logic [15:0] d;
      load = 1'b1;
      for (int k = 0; k < 40; k++) begin
         a = 9'($urandom_range(0, 511));
         d = 16'($urandom);
         address = a;
         in      = d;
         clock_edge();
         n_cmp++;
         if (out !== d) begin
            n_err++;
            $display("FAIL b2b_write addr=%0d got=%h exp=%h", a, out, d);
         end
      end
      load = 1'b0;
      for (int i = 0; i < 512; i++) begin
         address = 9'(i);
         #1;
         n_cmp++;
         if (out !== ref_mem[i]) begin
            n_err++;
            $display("FAIL b2b_sweep addr=%0d got=%h exp=%h", i, out, ref_mem[i]);
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         address = 9'($urandom_range(0, 511));
         in      = 16'($urandom);
         load    = 1'($urandom_range(0, 1));
         #1;
         n_cmp++;
         if (out !== ref_mem[address]) begin
            n_err++;
            $display("FAIL random_read addr=%0d got=%h exp=%h", address, out, ref_mem[address]);
         end
         clock_edge();
      end
      load = 1'b0;
   endtask

   task automatic test_reset_priority();
      address = 9'd5;
      in      = 16'h7777;
      load    = 1'b1;
      reset   = 1'b1;
      clock_edge();
      reset   = 1'b0;
      load    = 1'b0;
      #1;
      n_cmp++;
      if (out !== 16'h0000) begin
         n_err++;
         $display("FAIL reset_priority_addr5 got=%h exp=0000", out);
      end
      for (int i = 0; i < 512; i++) begin
         address = 9'(i);
         #1;
         n_cmp++;
         if (out !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_priority_sweep addr=%0d got=%h exp=0000", i, out);
         end
      end
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      reset   = 1'b0;
      load    = 1'b0;
      address = '0;
      in      = '0;
      for (int i = 0; i < 512; i++) ref_mem[i] = 16'h0000;
      @(posedge clk);
      #1;
      test_reset();
      test_full_write();
      test_hold();
      test_bank_isolation();
      test_comb_timing();
      test_back_to_back();
      test_random();
      test_reset_priority();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
